// File: rtl/wb_dbg_pkg.sv
// Shared constants and state types for the Wishbone debug master.
// Command bytes, status bytes, FSM state and tx sub-phase encodings.
package wb_dbg_pkg;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ST_OK  = 8'hA5;
    localparam logic [7:0] ST_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TX_SEND = 2'd0,
        TX_GAP  = 2'd1,
        TX_WAIT = 2'd2
    } tx_ph_t;

endpackage

// File: rtl/wb_dbg_timer.sv
// Loadable saturating down-counter; expired is high while the count is 0.
// Ports: clk, reset (sync, active-high), load, value[W], expired.
module wb_dbg_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/wb_dbg_master.sv
// Host-driven Wishbone master: byte frames from a uart become bus cycles.
// Ports: clk, reset, rx_data/rx_valid, tx_data/tx_wr/tx_busy, wb_* master, busy.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(RX_TIMEOUT + 1);
    // Loaded with N-1: the zero count is itself the last waiting cycle.
    localparam logic [AW-1:0] ACK_LD = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RX_LD  = RW'(RX_TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    tx_ph_t      tx_ph;
    logic [1:0]  byte_cnt;
    logic [7:0]  tx_byte;
    logic [31:0] rd_shift;
    logic [2:0]  tx_left;
    logic        rx_load;
    logic        ack_load;
    logic        rx_exp;
    logic        ack_exp;

    wb_dbg_timer #(.W(RW)) u_rx_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (rx_load),
        .value   (RX_LD),
        .expired (rx_exp)
    );

    wb_dbg_timer #(.W(AW)) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (ack_load),
        .value   (ACK_LD),
        .expired (ack_exp)
    );

    always_comb begin
        state_n  = state;
        rx_load  = 1'b0;
        ack_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_n = S_ADDR;
                        rx_load = 1'b1;
                    end else begin
                        state_n = S_RESP;
                    end
                end
            end
            S_ADDR, S_WDATA: begin
                if (rx_valid) begin
                    rx_load = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        if (state == S_ADDR && wb_we_o) begin
                            state_n = S_WDATA;
                        end else begin
                            state_n = S_BUS;
                        end
                    end
                end else if (rx_exp) begin
                    state_n = S_IDLE;
                end
            end
            S_BUS: begin
                if (!wb_cyc_o) begin
                    ack_load = 1'b1;
                end else if (wb_ack_i || ack_exp) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ph == TX_WAIT && !tx_busy && tx_left == 3'd0) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_ph    <= TX_SEND;
            byte_cnt <= '0;
            tx_byte  <= '0;
            rd_shift <= '0;
            tx_left  <= '0;
            tx_data  <= '0;
            tx_wr    <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            state <= state_n;
            tx_wr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        wb_we_o  <= (rx_data == CMD_WR);
                        byte_cnt <= '0;
                        tx_byte  <= ST_ERR;
                        tx_left  <= '0;
                        tx_ph    <= TX_SEND;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        tx_byte  <= ST_OK;
                        tx_ph    <= TX_SEND;
                        if (!wb_we_o) begin
                            rd_shift <= wb_dat_i;
                            tx_left  <= 3'd4;
                        end else begin
                            tx_left  <= 3'd0;
                        end
                    end else if (ack_exp) begin
                        wb_cyc_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        tx_byte  <= ST_ERR;
                        tx_left  <= 3'd0;
                        tx_ph    <= TX_SEND;
                    end
                end
                S_RESP: begin
                    unique case (tx_ph)
                        TX_SEND: begin
                            if (!tx_busy) begin
                                tx_wr   <= 1'b1;
                                tx_data <= tx_byte;
                                tx_ph   <= TX_GAP;
                            end
                        end
                        // uart raises busy one cycle late; skip that cycle
                        TX_GAP: tx_ph <= TX_WAIT;
                        TX_WAIT: begin
                            if (!tx_busy && tx_left != 3'd0) begin
                                tx_byte  <= rd_shift[31:24];
                                rd_shift <= {rd_shift[23:0], 8'h00};
                                tx_left  <= tx_left - 3'd1;
                                tx_ph    <= TX_SEND;
                            end
                        end
                        default: tx_ph <= TX_SEND;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign wb_stb_o = wb_cyc_o;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master with uart and Wishbone slave models.
// Uses shortened timeouts so the gap and ack boundaries are reachable.
module tb_wb_dbg_master;

    localparam int ACK_TO = 16;
    localparam int RX_TO  = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy;

    always #5 clk = ~clk;

    wb_dbg_master #(.ACK_TIMEOUT(ACK_TO), .RX_TIMEOUT(RX_TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .busy     (busy)
    );

    int total = 0;
    int bad = 0;

    // uart model: busy for 6 cycles after each load
    logic [7:0] txq[$];
    int tx_viol = 0;
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_wr) begin
            if (tx_busy) tx_viol++;
            txq.push_back(tx_data);
            busy_cnt = 6;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end
    end

    // slave model: ack during the ack_delay-th cycle of cyc
    logic        ack_en = 1'b0;
    logic        force_ack = 1'b0;
    logic        model_ack = 1'b0;
    int          ack_delay = 3;
    int          bus_cnt = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          stb_viol = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] cap_adr = '0;
    logic [31:0] cap_dat = '0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_sel = '0;
    assign wb_ack_i = model_ack | force_ack;

    always @(negedge clk) begin
        if (wb_stb_o !== wb_cyc_o) stb_viol++;
        if (wb_cyc_o) begin
            if (!prev_cyc) begin
                bus_cnt++;
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_we  = wb_we_o;
                cap_sel = wb_sel_o;
                cur_len = 0;
            end
            cur_len++;
            last_len = cur_len;
            model_ack = ack_en && (cur_len == ack_delay);
        end else begin
            model_ack = 1'b0;
        end
        prev_cyc = wb_cyc_o;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] txb(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    task automatic clr();
        txq.delete();
        bus_cnt = 0;
        tx_viol = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
        check("rst_txwr", {31'b0, tx_wr}, 32'h0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        reset = 1'b0;

        // write 0x40000004 <= 0xDEADBEEF, ack on 3rd cycle
        clr();
        ack_en = 1'b1;
        ack_delay = 3;
        send_byte(8'h01);
        send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'hDE); send_byte(8'hAD);
        send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("wr_idle", 200);
        check("wr_bus_cnt", bus_cnt, 1);
        check("wr_adr", cap_adr, 32'h40000004);
        check("wr_dat", cap_dat, 32'hDEADBEEF);
        check("wr_we", {31'b0, cap_we}, 32'h1);
        check("wr_sel", {28'b0, cap_sel}, 32'hF);
        check("wr_len", last_len, 3);
        check("wr_tx_n", txq.size(), 1);
        check("wr_tx0", {24'b0, txb(0)}, 32'hA5);

        // read 0x00000010 returns 0x12345678
        clr();
        wb_dat_i = 32'h12345678;
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h10);
        wait_idle("rd_idle", 300);
        check("rd_bus_cnt", bus_cnt, 1);
        check("rd_adr", cap_adr, 32'h00000010);
        check("rd_we", {31'b0, cap_we}, 32'h0);
        check("rd_tx_n", txq.size(), 5);
        check("rd_tx0", {24'b0, txb(0)}, 32'hA5);
        check("rd_tx1", {24'b0, txb(1)}, 32'h12);
        check("rd_tx2", {24'b0, txb(2)}, 32'h34);
        check("rd_tx3", {24'b0, txb(3)}, 32'h56);
        check("rd_tx4", {24'b0, txb(4)}, 32'h78);
        check("rd_tx_viol", tx_viol, 0);

        // ack timeout on read of 0x90000000
        clr();
        ack_en = 1'b0;
        send_byte(8'h02);
        send_byte(8'h90); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        wait_idle("to_idle", ACK_TO + 200);
        check("to_bus_cnt", bus_cnt, 1);
        check("to_len", last_len, ACK_TO);
        check("to_tx_n", txq.size(), 1);
        check("to_tx0", {24'b0, txb(0)}, 32'hEE);

        // unknown command
        clr();
        ack_en = 1'b1;
        send_byte(8'h55);
        check("unk_busy", {31'b0, busy}, 32'h1);
        wait_idle("unk_idle", 100);
        check("unk_bus_cnt", bus_cnt, 0);
        check("unk_tx_n", txq.size(), 1);
        check("unk_tx0", {24'b0, txb(0)}, 32'hEE);

        // gap timeout: busy through the RX_TO-th idle cycle, idle after
        clr();
        send_byte(8'h01);
        send_byte(8'h40);
        repeat (RX_TO - 1) @(negedge clk);
        check("gap_last", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("gap_drop", {31'b0, busy}, 32'h0);
        repeat (5) @(negedge clk);
        check("gap_bus_cnt", bus_cnt, 0);
        check("gap_tx_n", txq.size(), 0);

        // read with one byte arriving exactly on the expiry cycle
        clr();
        wb_dat_i = 32'hCAFE0123;
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00);
        repeat (RX_TO - 2) @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h20);
        wait_idle("gr_idle", 300);
        check("gr_bus_cnt", bus_cnt, 1);
        check("gr_adr", cap_adr, 32'h00000020);
        check("gr_tx_n", txq.size(), 5);
        check("gr_tx0", {24'b0, txb(0)}, 32'hA5);
        check("gr_tx1", {24'b0, txb(1)}, 32'hCA);
        check("gr_tx4", {24'b0, txb(4)}, 32'h23);

        // reset while cyc is high, then a stray ack
        clr();
        ack_en = 1'b0;
        send_byte(8'h02);
        send_byte(8'h30); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        begin
            int n = 0;
            while (!wb_cyc_o && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rs_cyc_before", {31'b0, wb_cyc_o}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rs_cyc", {31'b0, wb_cyc_o}, 32'h0);
        check("rs_stb", {31'b0, wb_stb_o}, 32'h0);
        check("rs_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (20) @(negedge clk);
        check("rs_busy_after", {31'b0, busy}, 32'h0);
        check("rs_tx_n", txq.size(), 0);
        check("rs_bus_cnt", bus_cnt, 1);
        check("stb_eq_cyc", stb_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
